// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, imem req/valid handshake, registered instr with valid/ready
// One instruction is in flight at a time; a redirect on any edge overrides everything else.
module instr_fetch_unit #(
   parameter int                PC_W     = 8,
   parameter int                INSTR_W  = 8,
   parameter logic [PC_W-1:0]   RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 imem_req,
   output logic [PC_W-1:0]      imem_addr,
   input  logic [INSTR_W-1:0]   imem_rdata,
   input  logic                 imem_valid,
   output logic [INSTR_W-1:0]   instr,
   output logic [1:0]           opcode,
   output logic [PC_W-1:0]      instr_pc,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   input  logic                 redirect,
   input  logic [PC_W-1:0]      redirect_target
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [PC_W-1:0]      instr_pc_q, instr_pc_d;
   logic                 instr_valid_q, instr_valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      if (redirect) begin
         // Any same-cycle memory response or downstream accept is dropped.
         pc_d          = redirect_target;
         instr_valid_d = 1'b0;
         state_d       = FETCH;
      end else begin
         unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (imem_valid) begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = pc_q;
                  pc_d          = pc_q + PC_W'(1);
                  instr_valid_d = 1'b1;
                  state_d       = HOLD;
               end
            end
            HOLD: begin
               if (instr_valid_q && instr_ready) begin
                  instr_valid_d = 1'b0;
                  state_d       = FETCH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[INSTR_W-1:INSTR_W-2];
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
// Memory model: mem[a] = a ^ 8'h5A, returned in the same cycle as the request.
module tb_instr_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic       imem_valid;
   logic [7:0] instr;
   logic [1:0] opcode;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       redirect;
   logic [7:0] redirect_target;

   logic       w_rst_n;
   logic       w_imem_req;
   logic [7:0] w_imem_addr;
   logic [7:0] w_imem_rdata;
   logic [7:0] w_instr;
   logic [1:0] w_opcode;
   logic [7:0] w_instr_pc;
   logic       w_instr_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_rdata   = imem_addr ^ 8'h5A;
   assign w_imem_rdata = w_imem_addr ^ 8'h5A;

   instr_fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .redirect(redirect), .redirect_target(redirect_target)
   );

   instr_fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'hFE)) dut_wrap (
      .clk(clk), .rst_n(w_rst_n),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_rdata(w_imem_rdata), .imem_valid(1'b1),
      .instr(w_instr), .opcode(w_opcode), .instr_pc(w_instr_pc),
      .instr_valid(w_instr_valid), .instr_ready(1'b1),
      .redirect(1'b0), .redirect_target(8'h00)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; w_rst_n = 1'b0;
      imem_valid = 1'b1; instr_ready = 1'b1;
      redirect = 1'b0; redirect_target = 8'h00;
      step(); step();
      chk("rst_req",   imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_op",    opcode, 0);
      chk("rst_instr", instr, 0);
      chk("rst_addr",  imem_addr, 8'h00);

      // Sequential fetch, memory always ready, downstream always ready
      rst_n = 1'b1;
      step();
      chk("t1_req0",  imem_req, 1);
      chk("t1_addr0", imem_addr, 8'h00);
      step();
      chk("t1_instr0", instr, 8'h5A);
      chk("t1_pc0",    instr_pc, 8'h00);
      chk("t1_vld0",   instr_valid, 1);
      chk("t1_op0",    opcode, 2'b01);
      chk("t1_noreq",  imem_req, 0);
      step();
      chk("t1_addr1", imem_addr, 8'h01);
      chk("t1_vdrop", instr_valid, 0);
      step();
      chk("t1_instr1", instr, 8'h5B);
      chk("t1_pc1",    instr_pc, 8'h01);
      step();
      chk("t1_addr2", imem_addr, 8'h02);
      step();
      chk("t1_instr2", instr, 8'h58);
      chk("t1_pc2",    instr_pc, 8'h02);

      // Back-pressure for 5 cycles
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_instr", instr, 8'h58);
         chk("t3_pc",    instr_pc, 8'h02);
         chk("t3_vld",   instr_valid, 1);
         chk("t3_req",   imem_req, 0);
      end
      instr_ready = 1'b1;
      step();
      chk("t3_vdrop", instr_valid, 0);
      chk("t3_addr",  imem_addr, 8'h03);
      chk("t3_req1",  imem_req, 1);
      step();
      chk("t3_instr3", instr, 8'h59);
      step();
      chk("t2_addr4", imem_addr, 8'h04);

      // Three memory wait states at address 4
      imem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_waddr", imem_addr, 8'h04);
         chk("t2_wvld",  instr_valid, 0);
         chk("t2_wreq",  imem_req, 1);
      end
      imem_valid = 1'b1;
      step();
      chk("t2_instr4", instr, 8'h5E);
      chk("t2_pc4",    instr_pc, 8'h04);
      chk("t2_vld",    instr_valid, 1);
      step(); step();
      chk("t2_instr5", instr, 8'h5F);
      step(); step();
      chk("t4_instr6", instr, 8'h5C);
      step();
      chk("t4_addr7", imem_addr, 8'h07);

      // Redirect on the same edge as a valid response at address 7
      redirect = 1'b1; redirect_target = 8'h40;
      step();
      redirect = 1'b0;
      chk("t4_addr",  imem_addr, 8'h40);
      chk("t4_vld",   instr_valid, 0);
      chk("t4_instr", instr, 8'h5C);
      chk("t4_ipc",   instr_pc, 8'h06);
      chk("t4_req",   imem_req, 1);
      step();
      chk("t4_instr40", instr, 8'h1A);
      chk("t4_pc40",    instr_pc, 8'h40);
      chk("t4_op40",    opcode, 2'b00);

      // Asynchronous reset between edges while holding
      instr_ready = 1'b0;
      step();
      chk("t6_hold", instr_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_vld",   instr_valid, 0);
      chk("t6_op",    opcode, 0);
      chk("t6_req",   imem_req, 0);
      chk("t6_instr", instr, 0);
      instr_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      chk("t6_req1", imem_req, 1);
      chk("t6_addr", imem_addr, 8'h00);
      step();
      chk("t6_instr", instr, 8'h5A);

      // PC wrap from 0xFE
      chk("t5_rst", w_instr_valid, 0);
      w_rst_n = 1'b1;
      step(); step();
      chk("t5_pcFE", w_instr_pc, 8'hFE);
      chk("t5_iFE",  w_instr, 8'hA4);
      step(); step();
      chk("t5_pcFF", w_instr_pc, 8'hFF);
      step(); step();
      chk("t5_pc00", w_instr_pc, 8'h00);
      chk("t5_i00",  w_instr, 8'h5A);
      step(); step();
      chk("t5_pc01", w_instr_pc, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
